// File: rtl/bram_sdp_fifo_reader_pkg.sv
// Shared helpers for the Xilinx block-RAM wrappers:
// performance-mode names and the read latency each one implies.
package bram_sdp_fifo_reader_pkg;

    typedef logic [8*16-1:0] perf_t;

    localparam perf_t PERF_HIGH = "HIGH_PERFORMANCE";
    localparam perf_t PERF_LOW  = "LOW_LATENCY";

    function automatic int unsigned rd_lat(input perf_t perf);
        return (perf == PERF_LOW) ? 1 : 2;
    endfunction

endpackage

// File: rtl/bram_sdp_fifo_reader_if.sv
// Valid/ready stream bundle; master drives valid/data,
// slave drives ready.
interface bram_sdp_fifo_reader_if #(
    parameter int DATA_WIDTH = 64
);
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/bram_sdp_fifo_reader_ram.sv
// Simple dual-port, single-clock block RAM (port A write,
// port B read) with optional output register.
module xilinx_simple_dual_port_1_clock_ram
    import bram_sdp_fifo_reader_pkg::*;
#(
    parameter int    RAM_WIDTH       = 64,
    parameter int    RAM_DEPTH       = 512,
    parameter perf_t RAM_PERFORMANCE = PERF_HIGH,
    parameter        INIT_FILE       = ""
) (
    input  logic                         clka,
    input  logic [$clog2(RAM_DEPTH)-1:0] addra,
    input  logic [$clog2(RAM_DEPTH)-1:0] addrb,
    input  logic [RAM_WIDTH-1:0]         dina,
    input  logic                         wea,
    input  logic                         enb,
    input  logic                         rstb,
    input  logic                         regceb,
    output logic [RAM_WIDTH-1:0]         doutb
);

    localparam bit unused_init = (INIT_FILE == "");

    logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];
    logic [RAM_WIDTH-1:0] ram_data;

    always_ff @(posedge clka) begin
        if (wea)
            mem[addra] <= dina;
        if (enb)
            ram_data <= mem[addrb];
    end

    if (rd_lat(RAM_PERFORMANCE) == 1) begin : g_low_latency
        logic unused_ctl;
        assign unused_ctl = ^{rstb, regceb};
        assign doutb = ram_data;
    end else begin : g_high_perf
        always_ff @(posedge clka) begin
            if (rstb)
                doutb <= '0;
            else if (regceb)
                doutb <= ram_data;
        end
    end

endmodule

// File: rtl/bram_sdp_fifo_reader.sv
// Block-RAM FIFO: prefetches through the RAM's fixed read latency
// into a small flop skid buffer so the consumer sees a plain stream.
module bram_sdp_fifo_reader
    import bram_sdp_fifo_reader_pkg::*;
#(
    parameter int    DATA_WIDTH      = 64,
    parameter int    DEPTH           = 512,
    parameter perf_t RAM_PERFORMANCE = PERF_HIGH,
    localparam int   RD_LAT          = int'(rd_lat(RAM_PERFORMANCE)),
    localparam int   SKID_DEPTH      = RD_LAT + 1,
    localparam int   AW              = $clog2(DEPTH),
    localparam int   CW              = $clog2(DEPTH + SKID_DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    bram_sdp_fifo_reader_if.slave  s,
    bram_sdp_fifo_reader_if.master m,
    output logic [CW-1:0]          count
);

    localparam int SW = $clog2(SKID_DEPTH + 1);

    logic [AW-1:0]         wptr;
    logic [AW-1:0]         rptr;
    logic [AW:0]           ram_count;
    logic [RD_LAT-1:0]     vpipe;
    logic [SW-1:0]         skid_count;
    logic [SW-1:0]         inflight;
    logic [SW-1:0]         wr_idx;
    logic [DATA_WIDTH-1:0] skid_mem [SKID_DEPTH];
    logic [DATA_WIDTH-1:0] doutb;
    logic                  push;
    logic                  pop;
    logic                  issue;
    logic                  capture;

    assign s.ready = (ram_count != (AW+1)'(DEPTH));
    assign m.valid = (skid_count != '0);
    assign m.data  = skid_mem[0];

    assign push    = s.valid && s.ready && !flush;
    assign pop     = m.valid && m.ready && !flush;
    assign capture = vpipe[RD_LAT-1] && !flush;
    assign wr_idx  = skid_count - SW'(pop);

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++)
            inflight = inflight + SW'(vpipe[i]);
    end

    // A slot freed by this cycle's pop is reusable by a read issued now;
    // without that credit the skid cannot sustain one beat per cycle.
    assign issue = !flush && (ram_count != '0) &&
        (int'(inflight) + int'(skid_count) < SKID_DEPTH + int'(pop));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr       <= '0;
            rptr       <= '0;
            ram_count  <= '0;
            vpipe      <= '0;
            skid_count <= '0;
            count      <= '0;
        end else if (flush) begin
            wptr       <= '0;
            rptr       <= '0;
            ram_count  <= '0;
            vpipe      <= '0;
            skid_count <= '0;
            count      <= '0;
        end else begin
            if (push)
                wptr <= wptr + AW'(1);
            if (issue)
                rptr <= rptr + AW'(1);
            ram_count  <= ram_count + (AW+1)'(push) - (AW+1)'(issue);
            vpipe      <= (vpipe << 1) | RD_LAT'(issue);
            skid_count <= skid_count + SW'(capture) - SW'(pop);
            count      <= count + CW'(push) - CW'(pop);
        end
    end

    // Head stays put when the last entry pops, so m.data holds its value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SKID_DEPTH; k++)
                skid_mem[k] <= '0;
        end else if (flush) begin
            for (int k = 0; k < SKID_DEPTH; k++)
                skid_mem[k] <= '0;
        end else begin
            for (int k = 0; k < SKID_DEPTH - 1; k++)
                if (pop && (k + 1 < int'(skid_count)))
                    skid_mem[k] <= skid_mem[k+1];
            for (int k = 0; k < SKID_DEPTH; k++)
                if (capture && (k == int'(wr_idx)))
                    skid_mem[k] <= doutb;
        end
    end

    xilinx_simple_dual_port_1_clock_ram #(
        .RAM_WIDTH       (DATA_WIDTH),
        .RAM_DEPTH       (DEPTH),
        .RAM_PERFORMANCE (RAM_PERFORMANCE),
        .INIT_FILE       ("")
    ) u_ram (
        .clka   (clk),
        .addra  (wptr),
        .addrb  (rptr),
        .dina   (s.data),
        .wea    (push),
        .enb    (issue),
        .rstb   (1'b0),
        .regceb (1'b1),
        .doutb  (doutb)
    );

endmodule

// File: tb/tb_bram_sdp_fifo_reader.sv
// Bench for bram_sdp_fifo_reader: one DUT per RAM mode, shared stimulus,
// per-DUT scoreboard plus directed latency/capacity/flush/reset checks.
module tb_bram_sdp_fifo_reader;
    import bram_sdp_fifo_reader_pkg::*;

    localparam int DW    = 64;
    localparam int DEPTH = 512;
    localparam int CW    = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          s_valid = 1'b0;
    logic          m_ready = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic [CW-1:0] cnt_hp;
    logic [CW-1:0] cnt_ll;

    bram_sdp_fifo_reader_if #(.DATA_WIDTH(DW)) s_hp ();
    bram_sdp_fifo_reader_if #(.DATA_WIDTH(DW)) m_hp ();
    bram_sdp_fifo_reader_if #(.DATA_WIDTH(DW)) s_ll ();
    bram_sdp_fifo_reader_if #(.DATA_WIDTH(DW)) m_ll ();

    assign s_hp.valid = s_valid;
    assign s_hp.data  = s_data;
    assign m_hp.ready = m_ready;
    assign s_ll.valid = s_valid;
    assign s_ll.data  = s_data;
    assign m_ll.ready = m_ready;

    bram_sdp_fifo_reader #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .RAM_PERFORMANCE(PERF_HIGH)
    ) u_hp (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .s(s_hp), .m(m_hp), .count(cnt_hp)
    );

    bram_sdp_fifo_reader #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .RAM_PERFORMANCE(PERF_LOW)
    ) u_ll (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .s(s_ll), .m(m_ll), .count(cnt_ll)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [DW-1:0] q_hp[$];
    logic [DW-1:0] q_ll[$];
    int            mdl_hp = 0;
    int            mdl_ll = 0;
    int            pops_hp = 0;
    int            pops_ll = 0;
    logic [DW-1:0] last_hp = '0;
    logic [DW-1:0] last_ll = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            q_hp.delete();
            mdl_hp = 0;
        end else begin
            check("hp_count", 64'(cnt_hp), 64'(mdl_hp));
            if (flush) begin
                q_hp.delete();
                mdl_hp = 0;
            end else begin
                if (m_hp.valid && m_ready) begin
                    check("hp_pop_nonempty", 64'(q_hp.size() != 0), 64'd1);
                    if (q_hp.size() != 0)
                        check("hp_pop_data", m_hp.data, q_hp.pop_front());
                    pops_hp++;
                    last_hp = m_hp.data;
                    mdl_hp--;
                end
                if (s_valid && s_hp.ready) begin
                    q_hp.push_back(s_data);
                    mdl_hp++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            q_ll.delete();
            mdl_ll = 0;
        end else begin
            check("ll_count", 64'(cnt_ll), 64'(mdl_ll));
            if (flush) begin
                q_ll.delete();
                mdl_ll = 0;
            end else begin
                if (m_ll.valid && m_ready) begin
                    check("ll_pop_nonempty", 64'(q_ll.size() != 0), 64'd1);
                    if (q_ll.size() != 0)
                        check("ll_pop_data", m_ll.data, q_ll.pop_front());
                    pops_ll++;
                    last_ll = m_ll.data;
                    mdl_ll--;
                end
                if (s_valid && s_ll.ready) begin
                    q_ll.push_back(s_data);
                    mdl_ll++;
                end
            end
        end
    end

    initial begin
        int n;
        int p0;
        int stalls;
        int mv;

        // reset state
        repeat (3) tick();
        check("rst_count", 64'(cnt_hp), 64'd0);
        check("rst_m_valid", 64'(m_hp.valid), 64'd0);
        check("rst_m_data", m_hp.data, 64'd0);
        check("rst_s_ready", 64'(s_hp.ready), 64'd1);
        rst_n = 1'b1;
        tick();

        // single beat latency
        m_ready = 1'b1;
        s_valid = 1'b1;
        s_data  = 64'hA5;
        tick();
        s_valid = 1'b0;
        check("t1_c1_count", 64'(cnt_hp), 64'd1);
        tick();
        check("t1_c2_ll_valid", 64'(m_ll.valid), 64'd0);
        tick();
        check("t1_c3_hp_valid", 64'(m_hp.valid), 64'd0);
        check("t1_c3_ll_valid", 64'(m_ll.valid), 64'd1);
        check("t1_c3_ll_data", m_ll.data, 64'hA5);
        tick();
        check("t1_c4_hp_valid", 64'(m_hp.valid), 64'd1);
        check("t1_c4_hp_data", m_hp.data, 64'hA5);
        check("t1_c4_count", 64'(cnt_hp), 64'd1);
        tick();
        check("t1_c5_count", 64'(cnt_hp), 64'd0);
        check("t1_c5_valid", 64'(m_hp.valid), 64'd0);
        check("t1_c5_hold", m_hp.data, 64'hA5);

        // fill to capacity, then drain
        m_ready = 1'b0;
        n = 0;
        for (int c = 0; c < 700; c++) begin
            s_valid = (n < 600);
            s_data  = 64'(n);
            if (s_valid && s_hp.ready)
                n++;
            tick();
        end
        s_valid = 1'b0;
        check("t2_accepts", 64'(n), 64'd515);
        check("t2_hp_count", 64'(cnt_hp), 64'd515);
        check("t2_hp_s_ready", 64'(s_hp.ready), 64'd0);
        check("t2_ll_count", 64'(cnt_ll), 64'd514);
        check("t2_head", m_hp.data, 64'd0);
        m_ready = 1'b1;
        repeat (600) tick();
        check("t2_drain_hp", 64'(cnt_hp), 64'd0);
        check("t2_drain_ll", 64'(cnt_ll), 64'd0);
        check("t2_last_hp", last_hp, 64'd514);

        // sustained streaming
        stalls = 0;
        p0 = 0;
        for (int c = 0; c < 2000; c++) begin
            s_valid = 1'b1;
            s_data  = 64'(1000 + c);
            if (c == 10)
                p0 = pops_hp;
            if (!s_hp.ready || !s_ll.ready)
                stalls++;
            tick();
        end
        check("t3_pops_window", 64'(pops_hp - p0), 64'd1990);
        check("t3_stalls", 64'(stalls), 64'd0);
        s_valid = 1'b0;
        repeat (10) tick();
        check("t3_empty_hp", 64'(cnt_hp), 64'd0);
        check("t3_last_hp", last_hp, 64'd2999);
        check("t3_last_ll", last_ll, 64'd2999);

        // random traffic
        for (int c = 0; c < 1500; c++) begin
            s_valid = ($urandom_range(0, 99) < 70);
            s_data  = {$urandom(), $urandom()};
            m_ready = $urandom_range(0, 1) == 1;
            tick();
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        repeat (600) tick();
        check("t4_cnt_hp", 64'(cnt_hp), 64'd0);
        check("t4_cnt_ll", 64'(cnt_ll), 64'd0);
        check("t4_q_hp", 64'(q_hp.size()), 64'd0);
        check("t4_q_ll", 64'(q_ll.size()), 64'd0);

        // flush with reads in flight
        m_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            s_valid = 1'b1;
            s_data  = 64'h500 + 64'(i);
            tick();
        end
        s_valid = 1'b0;
        repeat (8) tick();
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        flush   = 1'b1;
        tick();
        flush   = 1'b0;
        check("t5_count_hp", 64'(cnt_hp), 64'd0);
        check("t5_count_ll", 64'(cnt_ll), 64'd0);
        check("t5_valid_hp", 64'(m_hp.valid), 64'd0);
        check("t5_s_ready", 64'(s_hp.ready), 64'd1);
        m_ready = 1'b1;
        mv = 0;
        repeat (10) begin
            tick();
            if (m_hp.valid || m_ll.valid)
                mv++;
        end
        check("t5_no_stale", 64'(mv), 64'd0);
        s_valid = 1'b1;
        s_data  = 64'h77;
        tick();
        s_valid = 1'b0;
        repeat (8) tick();
        check("t5_first_hp", last_hp, 64'h77);
        check("t5_first_ll", last_ll, 64'h77);

        // async reset mid-stream
        for (int c = 0; c < 20; c++) begin
            s_valid = 1'b1;
            s_data  = 64'h600 + 64'(c);
            tick();
        end
        #2;
        rst_n   = 1'b0;
        s_valid = 1'b0;
        #1;
        check("t6_valid_hp", 64'(m_hp.valid), 64'd0);
        check("t6_count_hp", 64'(cnt_hp), 64'd0);
        check("t6_data_hp", m_hp.data, 64'd0);
        check("t6_s_ready", 64'(s_hp.ready), 64'd1);
        check("t6_count_ll", 64'(cnt_ll), 64'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        tick();
        p0 = pops_hp;
        s_valid = 1'b1;
        s_data  = 64'hBEEF;
        tick();
        s_valid = 1'b0;
        repeat (8) tick();
        check("t6_first_hp", last_hp, 64'hBEEF);
        check("t6_pops_hp", 64'(pops_hp - p0), 64'd1);
        check("t6_first_ll", last_ll, 64'hBEEF);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errs);
        $finish;
    end

endmodule
